// File: rtl/word_tokenizer.sv
`timescale 1ns/1ps
// word_tokenizer: splits a console byte stream into whitespace-delimited tokens,
// writes each NUL-terminated into the TIB, then runs a pool FIND and reports the result.
module word_tokenizer #(
    parameter int ASZ    = 17,
    parameter int DSZ    = 8,
    parameter int TIB    = 0,
    parameter int MAXLEN = 31
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx_vld,
    input  logic [7:0]     rx_dat,
    output logic           rx_rdy,
    output logic [1:0]     op,
    output logic [ASZ-1:0] ai,
    output logic [DSZ-1:0] vi,
    output logic           we,
    input  logic           bsy,
    input  logic           hit,
    input  logic [ASZ-1:0] ao0,
    input  logic [ASZ-1:0] ao1,
    output logic           tok_vld,
    input  logic           tok_rdy,
    output logic           tok_hit,
    output logic [ASZ-1:0] tok_pfa,
    output logic [5:0]     tok_len,
    output logic           tok_ovf
);

    typedef enum logic [2:0] {IDLE, COLLECT, TERM, FIND, WAIT, DONE} state_t;
    typedef enum logic [1:0] {OP_NOP = 2'd0, OP_R1 = 2'd1, OP_W1 = 2'd2, OP_FIND = 2'd3} op_t;

    localparam logic [ASZ-1:0] TIB_A = ASZ'(TIB);
    localparam logic [5:0]     MAX_L = 6'(MAXLEN);

    state_t         state, state_nx;
    logic [5:0]     len, len_nx;
    logic           ovf, ovf_nx;
    logic           armed, armed_nx;
    logic           latch;
    logic           accept, is_ws, is_bs;
    op_t            op_q, op_nx;
    logic [ASZ-1:0] ai_nx;
    logic [DSZ-1:0] vi_nx;
    logic           we_nx;
    logic           rdy_nx;
    logic [ASZ-1:0] tib_len;
    logic           unused_ao0;

    assign accept     = rx_vld & rx_rdy;
    assign is_ws      = rx_dat inside {8'h20, 8'h09, 8'h0A, 8'h0D};
    assign is_bs      = (rx_dat == 8'h08);
    assign tib_len    = TIB_A + ASZ'(len);
    assign op         = op_q;
    assign tok_vld    = (state == DONE);
    assign unused_ao0 = ^ao0;

    // Pool outputs are registered, so each op is launched one state early:
    // the terminator write shows while in TERM and the FIND pulse while in FIND.
    always_comb begin
        state_nx = state;
        len_nx   = len;
        ovf_nx   = ovf;
        armed_nx = 1'b0;
        latch    = 1'b0;
        op_nx    = OP_NOP;
        ai_nx    = '0;
        vi_nx    = '0;
        we_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !is_ws && !is_bs) begin
                    op_nx    = OP_W1;
                    ai_nx    = TIB_A;
                    vi_nx    = DSZ'(rx_dat);
                    we_nx    = 1'b1;
                    len_nx   = 6'd1;
                    state_nx = COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (is_bs) begin
                        if (len > 6'd1) begin
                            len_nx = len - 6'd1;
                        end else begin
                            len_nx   = '0;
                            state_nx = IDLE;
                        end
                    end else if (is_ws) begin
                        op_nx    = OP_W1;
                        ai_nx    = tib_len;
                        vi_nx    = '0;
                        we_nx    = 1'b1;
                        state_nx = TERM;
                    end else if (len < MAX_L) begin
                        op_nx  = OP_W1;
                        ai_nx  = tib_len;
                        vi_nx  = DSZ'(rx_dat);
                        we_nx  = 1'b1;
                        len_nx = len + 6'd1;
                    end else begin
                        ovf_nx = 1'b1;
                    end
                end
            end
            TERM: begin
                op_nx    = OP_FIND;
                ai_nx    = TIB_A;
                state_nx = FIND;
            end
            FIND: begin
                state_nx = WAIT;
            end
            WAIT: begin
                // First WAIT cycle only arms; bsy may not yet reflect the FIND.
                armed_nx = 1'b1;
                if (armed && !bsy) begin
                    latch    = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (tok_rdy) begin
                    len_nx   = '0;
                    ovf_nx   = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        rdy_nx = (state_nx == IDLE) || (state_nx == COLLECT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            len    <= '0;
            ovf    <= 1'b0;
            armed  <= 1'b0;
            rx_rdy <= 1'b0;
            op_q   <= OP_NOP;
            ai     <= '0;
            vi     <= '0;
            we     <= 1'b0;
        end else begin
            state  <= state_nx;
            len    <= len_nx;
            ovf    <= ovf_nx;
            armed  <= armed_nx;
            rx_rdy <= rdy_nx;
            op_q   <= op_nx;
            ai     <= ai_nx;
            vi     <= vi_nx;
            we     <= we_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tok_hit <= 1'b0;
            tok_pfa <= '0;
            tok_len <= '0;
            tok_ovf <= 1'b0;
        end else if (latch) begin
            tok_hit <= hit;
            tok_pfa <= hit ? ao1 : '0;
            tok_len <= len;
            tok_ovf <= ovf;
        end
    end

endmodule

// File: tb/tb_word_tokenizer.sv
`timescale 1ns/1ps
// tb_word_tokenizer: directed cases plus randomized token streams against a
// behavioural token model and a small dictionary pool model.
module tb_word_tokenizer;

    localparam int ASZ    = 17;
    localparam int DSZ    = 8;
    localparam int MAXLEN = 31;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           rx_vld, rx_rdy;
    logic [7:0]     rx_dat;
    logic [1:0]     op;
    logic [ASZ-1:0] ai;
    logic [DSZ-1:0] vi;
    logic           we;
    logic           bsy, hit;
    logic [ASZ-1:0] ao0, ao1;
    logic           tok_vld, tok_rdy, tok_hit, tok_ovf;
    logic [ASZ-1:0] tok_pfa;
    logic [5:0]     tok_len;

    always #5 clk = ~clk;

    word_tokenizer #(.ASZ(ASZ), .DSZ(DSZ), .TIB(0), .MAXLEN(MAXLEN)) dut (
        .clk(clk), .rst(rst), .rx_vld(rx_vld), .rx_dat(rx_dat), .rx_rdy(rx_rdy),
        .op(op), .ai(ai), .vi(vi), .we(we), .bsy(bsy), .hit(hit), .ao0(ao0), .ao1(ao1),
        .tok_vld(tok_vld), .tok_rdy(tok_rdy), .tok_hit(tok_hit), .tok_pfa(tok_pfa),
        .tok_len(tok_len), .tok_ovf(tok_ovf)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- dictionary and pool model ----------------
    logic [7:0]     dict [4][4];
    logic [ASZ-1:0] pfa_tab [4];
    logic [7:0]     mem [0:63];
    logic           long_busy = 1'b0;
    logic           pend;
    int             bcnt;

    function automatic logic [ASZ:0] pool_result();
        for (int k = 0; k < 4; k++) begin
            bit m = (mem[4] == 8'h00);
            for (int i = 0; i < 4; i++) if (mem[i] != dict[k][i]) m = 0;
            if (m) return {1'b1, pfa_tab[k]};
        end
        return {1'b0, ASZ'($urandom)};
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                bsy <= 1'b0; hit <= 1'b0; ao0 <= '0; ao1 <= '0; pend <= 1'b0; bcnt <= 0;
            end else begin
                if (op == 2'd2 && we) mem[ai[5:0]] <= vi;
                if (op == 2'd3) begin
                    hit <= 1'($urandom);
                    ao1 <= ASZ'($urandom);
                    if (!long_busy && $urandom_range(0, 1) == 1) pend <= 1'b1;
                    else begin
                        bsy  <= 1'b1;
                        bcnt <= long_busy ? 40 : int'($urandom_range(0, 4));
                    end
                end else if (pend) begin
                    pend <= 1'b0;
                    bsy  <= 1'b1;
                    bcnt <= int'($urandom_range(0, 4));
                end else if (bsy) begin
                    if (bcnt == 0) begin
                        bsy        <= 1'b0;
                        {hit, ao1} <= pool_result();
                        ao0        <= ASZ'($urandom);
                    end else begin
                        bcnt <= bcnt - 1;
                        hit  <= 1'($urandom);
                        ao1  <= ASZ'($urandom);
                    end
                end
            end
        end
    end

    // ---------------- behavioural token model ----------------
    typedef struct packed {
        logic           hit;
        logic [ASZ-1:0] pfa;
        logic [5:0]     len;
        logic           ovf;
        logic [7:0]     wr;
        logic [255:0]   txt;
    } exp_t;

    exp_t         expq [$];
    exp_t         e;
    logic [255:0] m_txt = '0;
    int           m_len = 0;
    bit           m_ovf = 0;
    int           m_wr = 0;
    int           wcnt = 0;
    int           last_wr = 0;
    bit           prev_find = 0;

    function automatic int dict_idx(input logic [255:0] t, input int n);
        if (n != 4) return -1;
        for (int k = 0; k < 4; k++) begin
            bit m = 1;
            for (int i = 0; i < 4; i++) if (t[8*i +: 8] != dict[k][i]) m = 0;
            if (m) return k;
        end
        return -1;
    endfunction

    function automatic void model_step(input logic [7:0] b);
        exp_t x;
        int   k;
        if (b inside {8'h20, 8'h09, 8'h0A, 8'h0D}) begin
            if (m_len > 0) begin
                k     = dict_idx(m_txt, m_len);
                x.hit = (k >= 0);
                x.pfa = '0;
                if (k >= 0) x.pfa = pfa_tab[k];
                x.len = 6'(m_len);
                x.ovf = m_ovf;
                x.wr  = 8'(m_wr + 1);
                x.txt = m_txt;
                expq.push_back(x);
                m_len = 0; m_ovf = 0; m_wr = 0; m_txt = '0;
            end
        end else if (b == 8'h08) begin
            if (m_len > 0) m_len--;
        end else if (m_len < MAXLEN) begin
            m_txt[8*m_len +: 8] = b;
            m_len++;
            m_wr++;
        end else begin
            m_ovf = 1;
        end
    endfunction

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                expq.delete();
                m_len = 0; m_ovf = 0; m_wr = 0; m_txt = '0; wcnt = 0; prev_find = 0;
            end else begin
                chk("we_only_w1", 64'(we), 64'(op == 2'd2));
                if (op == 2'd2) wcnt++;
                if (op == 2'd3) begin
                    chk("find_ai", 64'(ai), 64'd0);
                    chk("find_single", 64'(prev_find), 64'd0);
                    last_wr = wcnt;
                    if (expq.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL find_unexpected: got FIND, expected no pending token");
                    end else begin
                        e = expq[0];
                        chk("find_wr_count", 64'(wcnt), 64'(e.wr));
                        for (int i = 0; i <= int'(e.len); i++) begin
                            if (i == int'(e.len)) chk("tib_nul", 64'(mem[i]), 64'd0);
                            else chk("tib_byte", 64'(mem[i]), 64'(e.txt[8*i +: 8]));
                        end
                    end
                    wcnt = 0;
                end
                prev_find = (op == 2'd3);
                if (tok_vld) begin
                    chk("rx_backpressure", 64'(rx_rdy), 64'd0);
                    if (expq.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL tok_unexpected: got tok_vld=1, expected 0");
                    end else begin
                        e = expq[0];
                        chk("tok_hit", 64'(tok_hit), 64'(e.hit));
                        chk("tok_pfa", 64'(tok_pfa), 64'(e.pfa));
                        chk("tok_len", 64'(tok_len), 64'(e.len));
                        chk("tok_ovf", 64'(tok_ovf), 64'(e.ovf));
                        if (tok_rdy) void'(expq.pop_front());
                    end
                end
                if (rx_vld && rx_rdy) model_step(rx_dat);
            end
        end
    end

    // ---------------- consumer ----------------
    logic hold = 1'b0;
    logic rdy_always = 1'b1;

    initial begin
        tok_rdy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (hold) tok_rdy = 1'b0;
            else if (rdy_always) tok_rdy = 1'b1;
            else tok_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dat = b;
        rx_vld = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (rx_rdy) begin
                @(posedge clk); #1;
                rx_vld = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        rx_vld = 1'b0;
        n_vec++; n_err++;
        $display("FAIL rx_accept_timeout: got rx_rdy=0 for 300 cycles, expected 1");
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_tok(output bit ok);
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (tok_vld) begin
                ok = 1;
                return;
            end
        end
        ok = 0;
        n_vec++; n_err++;
        $display("FAIL tok_timeout: got tok_vld=0 for 300 cycles, expected 1");
    endtask

    task automatic zero_chk();
        chk("zero_rx_rdy", 64'(rx_rdy), 64'd0);
        chk("zero_op", 64'(op), 64'd0);
        chk("zero_ai", 64'(ai), 64'd0);
        chk("zero_vi", 64'(vi), 64'd0);
        chk("zero_we", 64'(we), 64'd0);
        chk("zero_tok_vld", 64'(tok_vld), 64'd0);
        chk("zero_tok_hit", 64'(tok_hit), 64'd0);
        chk("zero_tok_pfa", 64'(tok_pfa), 64'd0);
        chk("zero_tok_len", 64'(tok_len), 64'd0);
        chk("zero_tok_ovf", 64'(tok_ovf), 64'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    logic [7:0] wsb [4];
    bit         ok;

    initial begin
        string w [4];
        w = '{"abcd", "efgh", "ijkl", "mnop"};
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) dict[k][i] = w[k][i];
            pfa_tab[k] = ASZ'(17'h00104 * (k + 1));
        end
        wsb = '{8'h20, 8'h09, 8'h0A, 8'h0D};
        rx_vld = 1'b0;
        rx_dat = 8'h00;

        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        zero_chk();
        rst = 1'b1;
        step();

        // 1: dictionary hit
        send_str("efgh ");
        wait_tok(ok);
        if (ok) begin
            chk("t1_hit", 64'(tok_hit), 64'd1);
            chk("t1_len", 64'(tok_len), 64'd4);
            chk("t1_pfa", 64'(tok_pfa), 64'h00208);
            chk("t1_ovf", 64'(tok_ovf), 64'd0);
            chk("t1_tib0", 64'(mem[0]), 64'h65);
            chk("t1_tib3", 64'(mem[3]), 64'h68);
            chk("t1_tib4", 64'(mem[4]), 64'h00);
            chk("t1_writes", 64'(last_wr), 64'd5);
        end
        step();

        // 2: leading whitespace, miss
        send_str("  xyz\n");
        wait_tok(ok);
        if (ok) begin
            chk("t2_hit", 64'(tok_hit), 64'd0);
            chk("t2_pfa", 64'(tok_pfa), 64'd0);
            chk("t2_len", 64'(tok_len), 64'd3);
            chk("t2_tib0", 64'(mem[0]), 64'h78);
            chk("t2_tib3", 64'(mem[3]), 64'h00);
            chk("t2_writes", 64'(last_wr), 64'd4);
        end
        step();

        // 3: backspace edits the token
        send_str("abcx");
        send_byte(8'h08);
        send_str("d ");
        wait_tok(ok);
        if (ok) begin
            chk("t3_hit", 64'(tok_hit), 64'd1);
            chk("t3_len", 64'(tok_len), 64'd4);
            chk("t3_pfa", 64'(tok_pfa), 64'h00104);
            chk("t3_tib3", 64'(mem[3]), 64'h64);
            chk("t3_writes", 64'(last_wr), 64'd6);
        end
        step();

        // 4: overlong token truncated
        repeat (40) send_byte(8'h61);
        send_byte(8'h20);
        wait_tok(ok);
        if (ok) begin
            chk("t4_len", 64'(tok_len), 64'd31);
            chk("t4_ovf", 64'(tok_ovf), 64'd1);
            chk("t4_hit", 64'(tok_hit), 64'd0);
            chk("t4_tib30", 64'(mem[30]), 64'h61);
            chk("t4_tib31", 64'(mem[31]), 64'h00);
            chk("t4_writes", 64'(last_wr), 64'd32);
        end
        step();

        // 5: consumer stall back-pressures the stream
        hold = 1'b1;
        step();
        send_str("ijkl ");
        rx_dat = 8'h6D;
        rx_vld = 1'b1;
        wait_tok(ok);
        repeat (10) begin
            @(negedge clk);
            chk("t5_rx_rdy", 64'(rx_rdy), 64'd0);
            chk("t5_vld", 64'(tok_vld), 64'd1);
            chk("t5_len", 64'(tok_len), 64'd4);
            chk("t5_pfa", 64'(tok_pfa), 64'h0030C);
        end
        hold = 1'b0;
        send_byte(8'h6D);
        send_str("nop ");
        wait_tok(ok);
        if (ok) begin
            chk("t5b_hit", 64'(tok_hit), 64'd1);
            chk("t5b_pfa", 64'(tok_pfa), 64'h00410);
        end
        step();

        // 6: reset during a long search
        long_busy = 1'b1;
        send_str("abcd ");
        ok = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (bsy) begin
                ok = 1;
                break;
            end
        end
        chk("t6_saw_bsy", 64'(ok), 64'd1);
        #2 rst = 1'b0;
        #1 zero_chk();
        long_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        send_str("mnop ");
        wait_tok(ok);
        if (ok) begin
            chk("t6_hit", 64'(tok_hit), 64'd1);
            chk("t6_pfa", 64'(tok_pfa), 64'h00410);
            chk("t6_len", 64'(tok_len), 64'd4);
        end
        step();

        // random streams, random consumer readiness
        rdy_always = 1'b0;
        for (int t = 0; t < 60; t++) begin
            int kind;
            int n;
            int k;
            kind = int'($urandom_range(0, 9));
            k    = int'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) send_byte(8'h08);
            if (kind < 4) n = 4;
            else if (kind < 7) n = int'($urandom_range(1, 8));
            else if (kind < 8) n = int'($urandom_range(28, 38));
            else n = int'($urandom_range(2, 10));
            for (int i = 0; i < n; i++) begin
                if (kind < 4) send_byte(dict[k][i]);
                else send_byte(8'h61 + 8'($urandom_range(0, 15)));
                if (kind >= 8 && $urandom_range(0, 3) == 0) send_byte(8'h08);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step();
            end
            repeat ($urandom_range(1, 3)) send_byte(wsb[$urandom_range(0, 3)]);
        end

        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (expq.size() == 0 && !tok_vld) break;
        end
        chk("drain_empty", 64'(expq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
